// File: rtl/key_entry_ctrl.sv
// Keypad entry controller: 8-digit BCD entry with backspace/clear/enter, post-commit HOLD and an
// optional EDIT idle timeout (compiled in when KEY_ENTRY_TIMEOUT_EN is defined).
module key_entry_ctrl #(
    parameter int unsigned TIMEOUT_MS = 5000,
    parameter int unsigned HOLD_MS    = 500
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic        i_pls_1k,
    input  logic        i_key_valid,
    input  logic [4:0]  i_key_value,
    output logic [31:0] o_bcd8d,
    output logic        o_commit_valid,
    output logic [31:0] o_commit_data,
    output logic [1:0]  o_state
);

    // state  | meaning
    // S_IDLE | showing last committed value, waiting for a first digit
    // S_EDIT | collecting digits into entry, display shows entry
    // S_HOLD | showing freshly committed value for HOLD_MS ticks
    // S_BAD  | unreachable encoding, recovers to S_IDLE
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EDIT = 2'd1,
        S_HOLD = 2'd2,
        S_BAD  = 2'd3
    } state_t;

    localparam logic [15:0] TO_LAST   = 16'(TIMEOUT_MS - 1);
    localparam logic [15:0] HOLD_LAST = 16'(HOLD_MS - 1);

    state_t      state_q, state_d;
    logic [31:0] entry_q, entry_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] tmr_q, tmr_d;
    logic [31:0] commit_data_q, commit_data_d;
    logic        commit_valid_q, commit_valid_d;
    logic [31:0] bcd_q, bcd_d;

    logic is_digit, is_back, is_clr, is_ent;

    assign is_digit = i_key_valid && (i_key_value < 5'd10);
    assign is_back  = i_key_valid && (i_key_value == 5'd10);
    assign is_clr   = i_key_valid && (i_key_value == 5'd11);
    assign is_ent   = i_key_valid && (i_key_value == 5'd12);

`ifndef KEY_ENTRY_TIMEOUT_EN
    logic unused_timeout;
    assign unused_timeout = ^TO_LAST;
`endif

    always_comb begin
        state_d        = state_q;
        entry_d        = entry_q;
        cnt_d          = cnt_q;
        tmr_d          = tmr_q;
        commit_data_d  = commit_data_q;
        commit_valid_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (is_digit) begin
                    entry_d = {28'h0, i_key_value[3:0]};
                    cnt_d   = 4'd1;
                    tmr_d   = 16'd0;
                    state_d = S_EDIT;
                end
            end
            S_EDIT: begin
                if (i_key_valid) begin
                    // any key event, even an ignored code, restarts the idle timer
                    tmr_d = 16'd0;
                    if (is_digit && cnt_q < 4'd8) begin
                        entry_d = {entry_q[27:0], i_key_value[3:0]};
                        cnt_d   = cnt_q + 4'd1;
                    end else if (is_back && cnt_q != 4'd0) begin
                        entry_d = {4'h0, entry_q[31:4]};
                        cnt_d   = cnt_q - 4'd1;
                    end else if (is_clr) begin
                        entry_d = 32'h0;
                        cnt_d   = 4'd0;
                    end else if (is_ent && cnt_q != 4'd0) begin
                        commit_data_d  = entry_q;
                        commit_valid_d = 1'b1;
                        state_d        = S_HOLD;
                    end
                end
`ifdef KEY_ENTRY_TIMEOUT_EN
                else if (i_pls_1k) begin
                    if (tmr_q == TO_LAST) begin
                        entry_d = 32'h0;
                        cnt_d   = 4'd0;
                        tmr_d   = 16'd0;
                        state_d = S_IDLE;
                    end else begin
                        tmr_d = tmr_q + 16'd1;
                    end
                end
`endif
            end
            S_HOLD: begin
                if (i_pls_1k) begin
                    if (tmr_q == HOLD_LAST) begin
                        entry_d = 32'h0;
                        cnt_d   = 4'd0;
                        tmr_d   = 16'd0;
                        state_d = S_IDLE;
                    end else begin
                        tmr_d = tmr_q + 16'd1;
                    end
                end
            end
            default: begin
                entry_d = 32'h0;
                cnt_d   = 4'd0;
                tmr_d   = 16'd0;
                state_d = S_IDLE;
            end
        endcase

        bcd_d = (state_d == S_EDIT) ? entry_d : commit_data_d;
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q        <= S_IDLE;
            entry_q        <= 32'h0;
            cnt_q          <= 4'd0;
            tmr_q          <= 16'd0;
            commit_data_q  <= 32'h0;
            commit_valid_q <= 1'b0;
            bcd_q          <= 32'h0;
        end else begin
            state_q        <= state_d;
            entry_q        <= entry_d;
            cnt_q          <= cnt_d;
            tmr_q          <= tmr_d;
            commit_data_q  <= commit_data_d;
            commit_valid_q <= commit_valid_d;
            bcd_q          <= bcd_d;
        end
    end

    assign o_bcd8d        = bcd_q;
    assign o_commit_valid = commit_valid_q;
    assign o_commit_data  = commit_data_q;
    assign o_state        = state_q;

endmodule

// File: tb/tb_key_entry_ctrl.sv
// Directed bench for key_entry_ctrl: entry, overflow, backspace, commit/HOLD, timeout, reset.
module tb_key_entry_ctrl;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        pls = 1'b0;
    logic        kv = 1'b0;
    logic [4:0]  kval = 5'd0;
    logic [31:0] bcd;
    logic        cv;
    logic [31:0] cdata;
    logic [1:0]  st;

    int tests = 0;
    int fails = 0;
    int pulses = 0;

    always #5 clk = ~clk;

    key_entry_ctrl #(.TIMEOUT_MS(10), .HOLD_MS(500)) dut (
        .i_clk(clk), .i_rstn(rstn), .i_pls_1k(pls),
        .i_key_valid(kv), .i_key_value(kval),
        .o_bcd8d(bcd), .o_commit_valid(cv), .o_commit_data(cdata), .o_state(st)
    );

    always @(negedge clk) if (cv === 1'b1) pulses++;

    localparam logic [4:0] K_BACK = 5'd10, K_CLR = 5'd11, K_ENT = 5'd12;

    task automatic key(input logic [4:0] v);
        @(negedge clk); kv = 1'b1; kval = v;
        @(negedge clk); kv = 1'b0;
    endtask

    task automatic tick();
        @(negedge clk); pls = 1'b1;
        @(negedge clk); pls = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        tests++; if (bcd !== 32'h0) begin fails++; $display("FAIL reset_bcd got %h exp 0", bcd); end
        tests++; if (st !== 2'd0) begin fails++; $display("FAIL reset_state got %0d exp 0", st); end
        tests++; if (cv !== 1'b0 || cdata !== 32'h0) begin fails++; $display("FAIL reset_commit got %b/%h exp 0/0", cv, cdata); end
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_digits();
        key(5'd1); key(5'd2); key(5'd3);
        tests++; if (bcd !== 32'h123 || st !== 2'd1) begin fails++; $display("FAIL digits got %h/%0d exp 00000123/1", bcd, st); end
        key(5'd20);
        tests++; if (bcd !== 32'h123 || st !== 2'd1) begin fails++; $display("FAIL ignored_code got %h/%0d exp 00000123/1", bcd, st); end
        key(K_CLR);
        tests++; if (bcd !== 32'h0 || st !== 2'd1) begin fails++; $display("FAIL clr got %h/%0d exp 0/1", bcd, st); end
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 8; i++) key(5'(i));
        tests++; if (bcd !== 32'h12345678) begin fails++; $display("FAIL eight_digits got %h exp 12345678", bcd); end
        key(5'd9);
        tests++; if (bcd !== 32'h12345678) begin fails++; $display("FAIL ninth_digit got %h exp 12345678", bcd); end
        key(K_CLR);
    endtask

    task automatic test_backspace();
        key(5'd4); key(5'd5); key(K_BACK);
        tests++; if (bcd !== 32'h4) begin fails++; $display("FAIL back1 got %h exp 4", bcd); end
        key(K_BACK); key(K_BACK);
        tests++; if (bcd !== 32'h0 || st !== 2'd1) begin fails++; $display("FAIL back_empty got %h/%0d exp 0/1", bcd, st); end
        key(K_ENT);
        tests++; if (st !== 2'd1 || pulses != 0) begin fails++; $display("FAIL ent_empty got state %0d pulses %0d exp 1/0", st, pulses); end
        key(5'd6);
        tests++; if (bcd !== 32'h6) begin fails++; $display("FAIL digit_after_empty got %h exp 6", bcd); end
        key(K_CLR);
    endtask

    task automatic test_commit();
        key(5'd7); key(K_ENT);
        tests++; if (cv !== 1'b1 || cdata !== 32'h7 || st !== 2'd2 || bcd !== 32'h7) begin
            fails++; $display("FAIL commit got cv %b data %h st %0d bcd %h exp 1/7/2/7", cv, cdata, st, bcd); end
        @(negedge clk);
        tests++; if (cv !== 1'b0 || pulses != 1) begin fails++; $display("FAIL commit_pulse got cv %b pulses %0d exp 0/1", cv, pulses); end
        key(5'd9);
        tests++; if (bcd !== 32'h7 || st !== 2'd2) begin fails++; $display("FAIL hold_key got %h/%0d exp 7/2", bcd, st); end
        repeat (499) tick();
        tests++; if (st !== 2'd2) begin fails++; $display("FAIL hold_499 got %0d exp 2", st); end
        tick();
        tests++; if (st !== 2'd0 || bcd !== 32'h7 || cdata !== 32'h7) begin
            fails++; $display("FAIL hold_end got st %0d bcd %h data %h exp 0/7/7", st, bcd, cdata); end
    endtask

    task automatic test_timeout();
        key(5'd3);
        repeat (9) tick();
        tests++; if (st !== 2'd1 || bcd !== 32'h3) begin fails++; $display("FAIL pre_timeout got %0d/%h exp 1/3", st, bcd); end
`ifdef KEY_ENTRY_TIMEOUT_EN
        tick();
        tests++; if (st !== 2'd0 || bcd !== 32'h7 || cdata !== 32'h7 || pulses != 1) begin
            fails++; $display("FAIL timeout got st %0d bcd %h data %h pulses %0d exp 0/7/7/1", st, bcd, cdata, pulses); end
        key(5'd3);
        repeat (9) tick();
        @(negedge clk); kv = 1'b1; kval = 5'd4; pls = 1'b1;
        @(negedge clk); kv = 1'b0; pls = 1'b0;
        tests++; if (st !== 2'd1 || bcd !== 32'h34) begin fails++; $display("FAIL key_vs_tick got %0d/%h exp 1/34", st, bcd); end
        repeat (9) tick();
        tests++; if (st !== 2'd1) begin fails++; $display("FAIL timer_restart got %0d exp 1", st); end
`else
        repeat (20) tick();
        tests++; if (st !== 2'd1 || bcd !== 32'h3) begin fails++; $display("FAIL no_timeout got %0d/%h exp 1/3", st, bcd); end
`endif
        key(K_CLR);
    endtask

    task automatic test_reset_mid();
        key(5'd5); key(5'd6);
        tests++; if (bcd !== 32'h56 || st !== 2'd1) begin fails++; $display("FAIL pre_reset got %h/%0d exp 56/1", bcd, st); end
        #2 rstn = 1'b0;
        #1;
        tests++; if (bcd !== 32'h0 || st !== 2'd0 || cv !== 1'b0 || cdata !== 32'h0) begin
            fails++; $display("FAIL async_reset got bcd %h st %0d cv %b data %h exp 0/0/0/0", bcd, st, cv, cdata); end
        @(negedge clk); rstn = 1'b1;
        key(K_CLR); key(K_ENT); key(K_BACK);
        tests++; if (bcd !== 32'h0 || st !== 2'd0 || pulses != 1) begin
            fails++; $display("FAIL idle_ignore got %h/%0d pulses %0d exp 0/0/1", bcd, st, pulses); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk); kv = 1'b1; kval = 5'd2;
        @(negedge clk); kval = 5'd8;
        @(negedge clk); kval = 5'd9;
        @(negedge clk); kval = K_ENT;
        @(negedge clk); kv = 1'b0;
        tests++; if (cv !== 1'b1 || cdata !== 32'h289 || st !== 2'd2) begin
            fails++; $display("FAIL back_to_back got cv %b data %h st %0d exp 1/289/2", cv, cdata, st); end
        @(negedge clk);
        tests++; if (cv !== 1'b0 || pulses != 2) begin fails++; $display("FAIL b2b_pulse got cv %b pulses %0d exp 0/2", cv, pulses); end
    endtask

    initial begin
        test_reset();
        test_digits();
        test_overflow();
        test_backspace();
        test_commit();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/key_entry_ctrl.md
# key_entry_ctrl

Keypad entry controller between `key_scan` and `seg8digit`. It consumes decoded key events (`o_key_valid`/`o_key_value` of `key_scan`) and sequences an 8-digit decimal entry with edit, commit and timeout behaviour. It drives the packed BCD word shown on the 8-digit display and hands committed values to downstream logic through a one-cycle strobe. In `key_seg_top` it replaces the plain `key_shift` stage.

## Interface
Parameters:
- `TIMEOUT_MS`, default 5000: idle time in EDIT, in 1 kHz ticks, before the entry is aborted. Range 1..65535.
- `HOLD_MS`, default 500: time spent in HOLD after a commit, in 1 kHz ticks. Range 1..65535.

Ports:
- `i_clk` in 1: system clock; the only clock.
- `i_rstn` in 1: reset, asynchronous, active-low.
- `i_pls_1k` in 1: one-cycle tick at 1 kHz, from `clk_pls`.
- `i_key_valid` in 1: one-cycle key event strobe.
- `i_key_value` in 5: key code; only sampled when `i_key_valid` = 1.
- `o_bcd8d` out 32: display word, 8 BCD nibbles; [3:0] is the rightmost digit.
- `o_commit_valid` out 1: one-cycle strobe marking a committed value.
- `o_commit_data` out 32: last committed BCD value; holds until the next commit.
- `o_state` out 2: current state. 0 = IDLE, 1 = EDIT, 2 = HOLD.

## Operation
- Key codes:
  - 0–9 = digit.
  - 10 = BACK (backspace).
  - 11 = CLR (clear).
  - 12 = ENT (enter).
  - 13–31 are ignored in every state.
- Internal registers:
  - `entry[31:0]`: the entry buffer.
  - `cnt[3:0]`: digits entered, 0..8.
  - `tmr[15:0]`: ms timer.
- IDLE:
  - `o_bcd8d` = `o_commit_data`.
  - A digit key sets `entry` = {28'h0, d}, `cnt` = 1, clears `tmr`, and moves to EDIT.
  - BACK, CLR and ENT are ignored.
- EDIT:
  - `o_bcd8d` = `entry`.
  - Digit with `cnt` < 8: `entry` <= {`entry`[27:0], d}, `cnt`+1. Digit with `cnt` = 8: ignored.
  - BACK with `cnt` > 0: `entry` <= {4'h0, `entry`[31:4]}, `cnt`-1. BACK with `cnt` = 0: ignored, stays in EDIT.
  - CLR: `entry` = 0, `cnt` = 0, stays in EDIT.
  - ENT with `cnt` > 0: `o_commit_data` <= `entry`, pulse `o_commit_valid`, clear `tmr`, go to HOLD. ENT with `cnt` = 0: ignored.
  - Every accepted or ignored key event in EDIT clears `tmr`.
- HOLD:
  - `o_bcd8d` = `o_commit_data`.
  - All keys are ignored.
  - `tmr` counts `i_pls_1k`. When `tmr` = `HOLD_MS`-1 and a tick occurs, clear `entry`/`cnt`/`tmr` and go to IDLE.
- EDIT timeout: `tmr` increments on `i_pls_1k`. When `tmr` = `TIMEOUT_MS`-1 and a tick occurs with no key that cycle, abort: `entry` = 0, `cnt` = 0, go to IDLE. `o_commit_data` is unchanged and there is no commit strobe.
- Simultaneous key event and expiring tick in the same cycle: the key wins and `tmr` clears.
- Illegal `o_state` encoding 3: go to IDLE on the next cycle.

## Timing
- Reset values (asynchronous): `o_bcd8d` = 0, `o_commit_valid` = 0, `o_commit_data` = 0, `o_state` = 0, `entry` = 0, `cnt` = 0, `tmr` = 0.
- Reset mid-entry discards the entry and the committed value; outputs go to reset values at once.
- All outputs are registered.
- A key at cycle N is reflected on `o_bcd8d`/`o_state` at cycle N+1.
- ENT at cycle N: `o_commit_valid` is high for exactly cycle N+1, with `o_commit_data` valid from N+1.
- Back-to-back keys on consecutive cycles are each processed. There is no backpressure; `key_scan` never stalls.
- HOLD lasts `HOLD_MS` ticks, ±1 tick phase.

## Configuration
- `KEY_ENTRY_TIMEOUT_EN`:
  - Defined: the EDIT timeout abort is compiled in as described above.
  - Undefined: `tmr` is used only in HOLD, and EDIT persists indefinitely until ENT or reset.

## Test plan
- Reset, then keys 1,2,3: `o_bcd8d` = 32'h00000123, `o_state` = 1.
- Keys 1..9 (9 digits): `o_bcd8d` = 32'h12345678; the 9th digit is ignored.
- Keys 4,5,BACK: `o_bcd8d` = 32'h00000004. Then BACK, BACK: 0 with `cnt` = 0, `o_state` = 1.
- Keys 7,ENT: `o_commit_valid` is high for exactly one cycle, `o_commit_data` = 32'h7. `o_state` = 2 for 500 ticks, then 0 with `o_bcd8d` = 32'h7. A key 9 during HOLD has no effect.
- With `KEY_ENTRY_TIMEOUT_EN` and `TIMEOUT_MS` = 10: key 3 followed by 10 ticks returns to IDLE, `o_bcd8d` = previous commit, no strobe. Repeat with key 4 arriving in the same cycle as the 10th tick: stays in EDIT with 32'h34.
- Assert `i_rstn` = 0 during EDIT with 32'h56: all outputs are 0 asynchronously; after release, CLR/ENT/BACK in IDLE are ignored.
